// File: rtl/voice_scheduler_pkg.sv
// -----------------------------------------------------------------------------
// vsynth_pkg
// Shared constants and the scheduler FSM state type for the voice synth slice.
// No ports.
// -----------------------------------------------------------------------------
package vsynth_pkg;

  localparam int NOTE_W      = 7;   // note number width (step ROM address)
  localparam int PROG_W      = 7;   // program/waveform number width
  localparam int PHASE_IDX_W = 7;   // wavetable phase index width
  localparam int SAMPLE_W    = 8;   // unsigned wavetable sample width
  localparam int STEP_W      = 16;  // step ROM data width

  // Per-voice walk: STEP -> ACC -> SMP -> MIX, repeated for every voice,
  // then one DONE cycle that presents the mix.
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_STEP,
    ST_ACC,
    ST_SMP,
    ST_MIX,
    ST_DONE
  } vs_state_e;

endpackage

// File: rtl/voice_scheduler_if.sv
// -----------------------------------------------------------------------------
// voice_scheduler_if
// Bundles the control, ROM and mix-output signals of voice_scheduler.
//   slave  : the scheduler's view (takes ticks/config/ROM data, drives ROM
//            addresses/enables and the mix output)
//   master : the surrounding system's view (control logic, ROMs, audio stage)
// Parameter NVOICES sets the voice index and mix widths.
// -----------------------------------------------------------------------------
interface voice_scheduler_if #(
  parameter int NVOICES = 8
);
  import vsynth_pkg::*;

  localparam int VW    = $clog2(NVOICES);
  localparam int MIX_W = SAMPLE_W + VW;

  logic                   sample_tick;
  logic                   cfg_we;
  logic [VW-1:0]          cfg_voice;
  logic [NOTE_W-1:0]      cfg_note;
  logic [PROG_W-1:0]      cfg_program;
  logic                   cfg_gate;
  logic                   step_ce;
  logic [NOTE_W-1:0]      step_a;
  logic [STEP_W-1:0]      step_d;
  logic                   smp_ce;
  logic [PHASE_IDX_W-1:0] smp_a0;
  logic [PROG_W-1:0]      smp_a1;
  logic [SAMPLE_W-1:0]    smp_d;
  logic [MIX_W-1:0]       mix_out;
  logic                   mix_valid;
  logic                   busy;

  modport master (
    output sample_tick, cfg_we, cfg_voice, cfg_note, cfg_program, cfg_gate,
    output step_d, smp_d,
    input  step_ce, step_a, smp_ce, smp_a0, smp_a1, mix_out, mix_valid, busy
  );

  modport slave (
    input  sample_tick, cfg_we, cfg_voice, cfg_note, cfg_program, cfg_gate,
    input  step_d, smp_d,
    output step_ce, step_a, smp_ce, smp_a0, smp_a1, mix_out, mix_valid, busy
  );

endinterface

// File: rtl/voice_scheduler_regfile.sv
// -----------------------------------------------------------------------------
// voice_regfile
// Per-voice note/program/gate/phase-accumulator storage.
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   cfg_we/cfg_voice/cfg_note/  config write port; a gate 0->1 write also
//   cfg_program/cfg_gate        clears that voice's accumulator (retrigger)
//   rd_voice                    voice selected by the scheduler
//   rd_note/rd_program/rd_gate/ combinational read of the selected voice
//   rd_acc
//   acc_we/acc_wdata            accumulator update of the selected voice
// A retrigger clear of a voice beats a same-cycle accumulator update of it.
// -----------------------------------------------------------------------------
module voice_regfile
  import vsynth_pkg::*;
#(
  parameter  int NVOICES = 8,
  parameter  int ACC_W   = 16,
  localparam int VW      = $clog2(NVOICES)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_we,
  input  logic [VW-1:0]     cfg_voice,
  input  logic [NOTE_W-1:0] cfg_note,
  input  logic [PROG_W-1:0] cfg_program,
  input  logic              cfg_gate,
  input  logic [VW-1:0]     rd_voice,
  output logic [NOTE_W-1:0] rd_note,
  output logic [PROG_W-1:0] rd_program,
  output logic              rd_gate,
  output logic [ACC_W-1:0]  rd_acc,
  input  logic              acc_we,
  input  logic [ACC_W-1:0]  acc_wdata
);

  logic [NOTE_W-1:0] note_q    [NVOICES];
  logic [PROG_W-1:0] program_q [NVOICES];
  logic              gate_q    [NVOICES];
  logic [ACC_W-1:0]  acc_q     [NVOICES];

  logic retrig;

  assign retrig     = cfg_we & cfg_gate & ~gate_q[cfg_voice];

  assign rd_note    = note_q[rd_voice];
  assign rd_program = program_q[rd_voice];
  assign rd_gate    = gate_q[rd_voice];
  assign rd_acc     = acc_q[rd_voice];

  // NOTE: this storage is small and must come out of reset silent and
  // retriggered, so it lives in resettable flops rather than a RAM macro.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NVOICES; i++) begin
        note_q[i]    <= '0;
        program_q[i] <= '0;
        gate_q[i]    <= 1'b0;
        acc_q[i]     <= '0;
      end
    end else begin
      if (cfg_we) begin
        note_q[cfg_voice]    <= cfg_note;
        program_q[cfg_voice] <= cfg_program;
        gate_q[cfg_voice]    <= cfg_gate;
      end
      if (acc_we) begin
        acc_q[rd_voice] <= acc_wdata;
      end
      // Placed after the update so the clear wins on a same-voice collision.
      if (retrig) begin
        acc_q[cfg_voice] <= '0;
      end
    end
  end

endmodule

// File: rtl/voice_scheduler.sv
// -----------------------------------------------------------------------------
// voice_scheduler
// Time-multiplexes one step ROM and one sample ROM across NVOICES voices.
// Each sample_tick walks all voices (step lookup, phase accumulate, sample
// fetch, mix) and presents the summed mix with a one-cycle mix_valid.
// Ports:
//   clk          system clock
//   rst          synchronous active-high reset
//   bus          voice_scheduler_if.slave: sample_tick, cfg_*, step ROM
//                (step_ce/step_a/step_d), sample ROM (smp_ce/smp_a0/smp_a1/
//                smp_d), mix_out/mix_valid, busy
//   overrun_cnt  (only with VOICE_SCHEDULER_OVERRUN_CNT_EN) saturating count
//                of sample_ticks dropped because a frame was in progress
// Frame length is 4*NVOICES+1 cycles; ticks arriving while busy are dropped.
// -----------------------------------------------------------------------------
module voice_scheduler
  import vsynth_pkg::*;
#(
  parameter int NVOICES = 8,
  parameter int ACC_W   = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  voice_scheduler_if.slave     bus
`ifdef VOICE_SCHEDULER_OVERRUN_CNT_EN
  ,
  output logic [7:0]           overrun_cnt
`endif
);

  localparam int VW    = $clog2(NVOICES);
  localparam int MIX_W = SAMPLE_W + VW;

  vs_state_e         state_q, state_d;
  logic [VW-1:0]     v_q;
  logic [MIX_W-1:0]  mix_q;
  logic [MIX_W-1:0]  mix_next;
  logic [MIX_W-1:0]  mix_out_q;
  logic [PROG_W-1:0] prog_snap_q;
  logic              gate_snap_q;
  logic              last_voice;

  logic              busy;
  logic              step_ce;
  logic              smp_ce;
  logic              mix_valid;
  logic              acc_we;

  logic [NOTE_W-1:0] rd_note;
  logic [PROG_W-1:0] rd_program;
  logic              rd_gate;
  logic [ACC_W-1:0]  rd_acc;
  logic [ACC_W-1:0]  acc_wdata;

  voice_regfile #(
    .NVOICES (NVOICES),
    .ACC_W   (ACC_W)
  ) u_regfile (
    .clk         (clk),
    .rst         (rst),
    .cfg_we      (bus.cfg_we),
    .cfg_voice   (bus.cfg_voice),
    .cfg_note    (bus.cfg_note),
    .cfg_program (bus.cfg_program),
    .cfg_gate    (bus.cfg_gate),
    .rd_voice    (v_q),
    .rd_note     (rd_note),
    .rd_program  (rd_program),
    .rd_gate     (rd_gate),
    .rd_acc      (rd_acc),
    .acc_we      (acc_we),
    .acc_wdata   (acc_wdata)
  );

  assign last_voice = (v_q == VW'(NVOICES - 1));

  // Gated-off voices park their phase at zero; otherwise wrap modulo 2^ACC_W.
  assign acc_wdata  = gate_snap_q ? (rd_acc + bus.step_d) : '0;
  assign mix_next   = mix_q + (gate_snap_q ? MIX_W'(bus.smp_d) : '0);

  // NOTE: state registers take non-blocking assignments so every flop samples
  // pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // NOTE: every output of this block is defaulted first, so no path through
  // the case can leave one unassigned and infer a latch.
  always_comb begin
    state_d   = state_q;
    busy      = 1'b1;
    step_ce   = 1'b0;
    smp_ce    = 1'b0;
    mix_valid = 1'b0;
    acc_we    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        busy = 1'b0;
        if (bus.sample_tick) state_d = ST_STEP;
      end
      ST_STEP: begin
        step_ce = 1'b1;
        state_d = ST_ACC;
      end
      ST_ACC: begin
        acc_we  = 1'b1;
        state_d = ST_SMP;
      end
      ST_SMP: begin
        smp_ce  = 1'b1;
        state_d = ST_MIX;
      end
      ST_MIX: begin
        state_d = last_voice ? ST_DONE : ST_STEP;
      end
      ST_DONE: begin
        mix_valid = 1'b1;
        state_d   = ST_IDLE;
      end
      default: begin
        busy    = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // The note is only consumed in STEP itself (as step_a), so only program
  // and gate need a snapshot for the later stages of the voice.
  // mix_out is loaded on the last MIX edge so it is already valid during the
  // DONE cycle that raises mix_valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      v_q         <= '0;
      mix_q       <= '0;
      mix_out_q   <= '0;
      prog_snap_q <= '0;
      gate_snap_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.sample_tick) begin
            v_q   <= '0;
            mix_q <= '0;
          end
        end
        ST_STEP: begin
          prog_snap_q <= rd_program;
          gate_snap_q <= rd_gate;
        end
        ST_MIX: begin
          mix_q <= mix_next;
          if (last_voice) mix_out_q <= mix_next;
          else            v_q       <= v_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // ROM addresses sit at zero whenever their enable is low.
  assign bus.step_ce   = step_ce;
  assign bus.step_a    = step_ce ? rd_note : '0;
  assign bus.smp_ce    = smp_ce;
  assign bus.smp_a0    = smp_ce ? rd_acc[ACC_W-1 -: PHASE_IDX_W] : '0;
  assign bus.smp_a1    = smp_ce ? prog_snap_q : '0;
  assign bus.mix_out   = mix_out_q;
  assign bus.mix_valid = mix_valid;
  assign bus.busy      = busy;

`ifdef VOICE_SCHEDULER_OVERRUN_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      overrun_cnt <= '0;
    end else if (bus.sample_tick && (state_q != ST_IDLE) && (overrun_cnt != 8'hFF)) begin
      overrun_cnt <= overrun_cnt + 8'd1;
    end
  end
`endif

endmodule
